// File: rtl/lcd_bus_pkg.sv
// Shared types and constants for the LCD bus read engine.
// The timing defaults assume a 25 MHz clock, where one cycle is 40 ns.
package lcd_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CMD_LO,
        CMD_HI,
        TURN,
        RD_LO,
        RD_HI,
        RELEASE
    } lcd_rd_state_t;

    localparam int LCD_WR_LOW_CYC  = 1;
    localparam int LCD_WR_HIGH_CYC = 1;
    localparam int LCD_RD_LOW_CYC  = 2;
    localparam int LCD_RD_HIGH_CYC = 3;

    localparam logic [7:0] LCD_CMD_RDID   = 8'h04;
    localparam logic [7:0] LCD_CMD_RDSTAT = 8'h09;

    function automatic int cyc_max(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lcd_strobe_timer.sv
// Phase timer shared by every strobe phase.
// Loading L-1 makes last rise in the L-th cycle of the phase.
module lcd_strobe_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// Read engine for the 8080-style LCD bus.
// It writes one command byte, performs the read strobes, and reports the captured bytes.
//   state   | meaning
//   IDLE    | waiting for start
//   REQ     | bus_req high, waiting for bus_gnt
//   CMD_LO  | command on db, lcd_wr low
//   CMD_HI  | lcd_wr high, command still driven
//   TURN    | db released, one cycle before the first read
//   RD_LO   | lcd_rd low, db sampled on the final edge
//   RD_HI   | lcd_rd high, byte reported in the first cycle
//   RELEASE | done pulse, bus dropped
module lcd_bus_reader
    import lcd_bus_pkg::*;
#(
    parameter int WR_LOW_CYC  = LCD_WR_LOW_CYC,
    parameter int WR_HIGH_CYC = LCD_WR_HIGH_CYC,
    parameter int RD_LOW_CYC  = LCD_RD_LOW_CYC,
    parameter int RD_HIGH_CYC = LCD_RD_HIGH_CYC,
    parameter int SKIP_DUMMY  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] cmd,
    input  logic [3:0] rd_len,
    output logic       busy,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       done,
    output logic       abort,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic [7:0] lcd_db_out,
    output logic       lcd_db_oe,
    input  logic [7:0] lcd_db_in,
    output logic       lcd_wr,
    output logic       lcd_rd,
    output logic       lcd_d_c
);

    localparam int TW    = $clog2(cyc_max(WR_LOW_CYC, WR_HIGH_CYC, RD_LOW_CYC, RD_HIGH_CYC)) + 1;
    localparam int CNT_W = 5;

    localparam logic [TW-1:0] WR_LO_LD = TW'(WR_LOW_CYC - 1);
    localparam logic [TW-1:0] WR_HI_LD = TW'(WR_HIGH_CYC - 1);
    localparam logic [TW-1:0] RD_LO_LD = TW'(RD_LOW_CYC - 1);
    localparam logic [TW-1:0] RD_HI_LD = TW'(RD_HIGH_CYC - 1);

    lcd_rd_state_t state, state_nxt;
    logic [7:0]       cmd_q, cmd_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             dummy_q, dummy_nxt;
    logic             lost_q, lost_nxt, lost_any, in_xfer;
    logic [7:0]       data_nxt;
    logic             valid_nxt, abort_nxt;
    logic             tmr_load, tmr_last;
    logic [TW-1:0]    tmr_val;

    cyc_legal: assert property (@(posedge clk)
        (WR_LOW_CYC > 0) && (WR_HIGH_CYC > 0) && (RD_LOW_CYC > 0) && (RD_HIGH_CYC > 0))
        else $error("lcd_bus_reader: phase cycle counts must be nonzero");

    lcd_strobe_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .last     (tmr_last)
    );

    assign in_xfer  = state inside {CMD_LO, CMD_HI, TURN, RD_LO, RD_HI};
    // Once the grant is lost it stays lost, so the rest of the transaction winds down cleanly.
    assign lost_any = lost_q | (in_xfer & ~bus_gnt);

    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd_q;
        cnt_nxt   = cnt_q;
        dummy_nxt = dummy_q;
        lost_nxt  = lost_any;
        data_nxt  = data;
        valid_nxt = 1'b0;
        abort_nxt = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    cmd_nxt   = cmd;
                    cnt_nxt   = {1'b0, rd_len} + CNT_W'(SKIP_DUMMY);
                    dummy_nxt = (SKIP_DUMMY != 0);
                    lost_nxt  = 1'b0;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    state_nxt = CMD_LO;
                    tmr_load  = 1'b1;
                    tmr_val   = WR_LO_LD;
                end
            end
            CMD_LO: begin
                if (tmr_last) begin
                    state_nxt = CMD_HI;
                    tmr_load  = 1'b1;
                    tmr_val   = WR_HI_LD;
                end
            end
            CMD_HI: begin
                if (tmr_last) begin
                    state_nxt = (cnt_q == '0 || lost_any) ? RELEASE : TURN;
                end
            end
            TURN: begin
                if (lost_any) begin
                    state_nxt = RELEASE;
                end else begin
                    state_nxt = RD_LO;
                    tmr_load  = 1'b1;
                    tmr_val   = RD_LO_LD;
                end
            end
            RD_LO: begin
                if (tmr_last) begin
                    state_nxt = RD_HI;
                    tmr_load  = 1'b1;
                    tmr_val   = RD_HI_LD;
                    dummy_nxt = 1'b0;
                    if (!dummy_q && !lost_any) begin
                        data_nxt  = lcd_db_in;
                        valid_nxt = 1'b1;
                    end
                end
            end
            RD_HI: begin
                if (tmr_last) begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                    if (cnt_nxt != '0 && !lost_any) begin
                        state_nxt = RD_LO;
                        tmr_load  = 1'b1;
                        tmr_val   = RD_LO_LD;
                    end else begin
                        state_nxt = RELEASE;
                    end
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == RELEASE && state != RELEASE) begin
            abort_nxt = lost_any;
        end
    end

    // Every pin is registered from the next-state value, so it changes together with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cmd_q      <= '0;
            cnt_q      <= '0;
            dummy_q    <= 1'b0;
            lost_q     <= 1'b0;
            busy       <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            done       <= 1'b0;
            abort      <= 1'b0;
            bus_req    <= 1'b0;
            lcd_db_out <= '0;
            lcd_db_oe  <= 1'b0;
            lcd_wr     <= 1'b1;
            lcd_rd     <= 1'b1;
            lcd_d_c    <= 1'b1;
        end else begin
            state      <= state_nxt;
            cmd_q      <= cmd_nxt;
            cnt_q      <= cnt_nxt;
            dummy_q    <= dummy_nxt;
            lost_q     <= lost_nxt;
            busy       <= !(state_nxt inside {IDLE, RELEASE});
            data       <= data_nxt;
            data_valid <= valid_nxt;
            done       <= (state_nxt == RELEASE);
            abort      <= abort_nxt;
            bus_req    <= !(state_nxt inside {IDLE, RELEASE});
            lcd_db_out <= (state_nxt inside {CMD_LO, CMD_HI}) ? cmd_nxt : 8'h00;
            lcd_db_oe  <= (state_nxt inside {CMD_LO, CMD_HI});
            lcd_wr     <= (state_nxt != CMD_LO);
            lcd_rd     <= (state_nxt != RD_LO);
            lcd_d_c    <= !(state_nxt inside {CMD_LO, CMD_HI});
        end
    end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Directed, table-driven bench for lcd_bus_reader.
// It uses two instances: one with the dummy read enabled and one without.
module tb_lcd_bus_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic [3:0] rd_len = 4'd0;
    logic       bus_gnt = 1'b1;
    logic [7:0] lcd_db_in = 8'h00;
    logic       sel = 1'b0;

    logic       a_busy, a_valid, a_done, a_abort, a_req, a_oe, a_wr, a_rd, a_dc;
    logic [7:0] a_data, a_db;
    logic       b_busy, b_valid, b_done, b_abort, b_req, b_oe, b_wr, b_rd, b_dc;
    logic [7:0] b_data, b_db;
    logic       start_a, start_b;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    always #5 clk = ~clk;

    lcd_bus_reader #(.SKIP_DUMMY(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .cmd(cmd), .rd_len(rd_len),
        .busy(a_busy), .data(a_data), .data_valid(a_valid), .done(a_done), .abort(a_abort),
        .bus_req(a_req), .bus_gnt(bus_gnt), .lcd_db_out(a_db), .lcd_db_oe(a_oe),
        .lcd_db_in(lcd_db_in), .lcd_wr(a_wr), .lcd_rd(a_rd), .lcd_d_c(a_dc)
    );

    lcd_bus_reader #(.SKIP_DUMMY(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .cmd(cmd), .rd_len(rd_len),
        .busy(b_busy), .data(b_data), .data_valid(b_valid), .done(b_done), .abort(b_abort),
        .bus_req(b_req), .bus_gnt(bus_gnt), .lcd_db_out(b_db), .lcd_db_oe(b_oe),
        .lcd_db_in(lcd_db_in), .lcd_wr(b_wr), .lcd_rd(b_rd), .lcd_d_c(b_dc)
    );

    logic       busy_m, valid_m, done_m, abort_m, req_m, oe_m, wr_m, rd_m, dc_m;
    logic [7:0] data_m, db_m;
    assign busy_m  = sel ? b_busy  : a_busy;
    assign valid_m = sel ? b_valid : a_valid;
    assign done_m  = sel ? b_done  : a_done;
    assign abort_m = sel ? b_abort : a_abort;
    assign req_m   = sel ? b_req   : a_req;
    assign oe_m    = sel ? b_oe    : a_oe;
    assign wr_m    = sel ? b_wr    : a_wr;
    assign rd_m    = sel ? b_rd    : a_rd;
    assign dc_m    = sel ? b_dc    : a_dc;
    assign data_m  = sel ? b_data  : a_data;
    assign db_m    = sel ? b_db    : a_db;

    typedef struct {
        logic       sel;
        logic [7:0] cmd;
        logic [3:0] len;
        int         gnt_rise;
        int         gnt_drop;
        int         restart;
        int         exp_rd;
        int         exp_valid;
        int         exp_done;
        logic       exp_abort;
        int         exp_wr_lo;
    } vec_t;

    vec_t       vecs[10];
    logic [7:0] resp[16];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   rd_n, val_n, done_c, wr_n, wr_first, dc_n, dc_first, db_bad, req_gap, idle_bad;
        logic prev_rd, ab;
        logic [4:0] end_flags;
        rd_n = 0; val_n = 0; done_c = -1; wr_n = 0; wr_first = -1; dc_n = 0; dc_first = -1;
        db_bad = 0; req_gap = 0; idle_bad = 0; prev_rd = 1'b1; ab = 1'b0; end_flags = '0;
        @(negedge clk);
        sel = v.sel; cmd = v.cmd; rd_len = v.len;
        start = 1'b1;
        bus_gnt = (v.gnt_rise == 0);
        for (int t = 1; t < 200 && done_c < 0; t++) begin
            @(negedge clk);
            start = (t == v.restart);
            bus_gnt = (t >= v.gnt_rise) && !(v.gnt_drop >= 0 && t >= v.gnt_drop);
            if (rd_m === 1'b0 && prev_rd === 1'b1) begin
                if (rd_n < 16) lcd_db_in = resp[rd_n];
                rd_n++;
            end
            prev_rd = rd_m;
            if (wr_m === 1'b0) begin
                wr_n++;
                if (wr_first < 0) wr_first = t;
                if (db_m !== v.cmd || oe_m !== 1'b1) db_bad++;
            end
            if (dc_m === 1'b0) begin
                dc_n++;
                if (dc_first < 0) dc_first = t;
            end
            if (valid_m === 1'b1) begin
                check($sformatf("v%0d data%0d", idx, val_n), data_m,
                      resp[(val_n + (v.sel ? 0 : 1)) % 16]);
                val_n++;
            end
            if (done_m === 1'b1) begin
                done_c = t;
                ab = abort_m;
                end_flags = {req_m, busy_m, rd_m, wr_m, oe_m};
            end else if (req_m !== 1'b1 || busy_m !== 1'b1) begin
                req_gap++;
            end
        end
        start = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            bus_gnt = 1'b1;
            if (busy_m !== 1'b0 || req_m !== 1'b0 || valid_m !== 1'b0 || done_m !== 1'b0) idle_bad++;
        end
        check($sformatf("v%0d rd_falls", idx), rd_n, v.exp_rd);
        check($sformatf("v%0d valid_count", idx), val_n, v.exp_valid);
        check($sformatf("v%0d done_cycle", idx), done_c, v.exp_done);
        check($sformatf("v%0d abort", idx), ab, v.exp_abort);
        check($sformatf("v%0d wr_low_count", idx), wr_n, 1);
        check($sformatf("v%0d wr_first", idx), wr_first, v.exp_wr_lo);
        check($sformatf("v%0d dc_low_count", idx), dc_n, 2);
        check($sformatf("v%0d dc_first", idx), dc_first, v.exp_wr_lo);
        check($sformatf("v%0d db_during_wr", idx), db_bad, 0);
        check($sformatf("v%0d req_busy_gap", idx), req_gap, 0);
        check($sformatf("v%0d end_flags", idx), end_flags, 5'b00110);
        check($sformatf("v%0d idle_after", idx), idle_bad, 0);
    endtask

    initial begin
        resp = '{8'hFF, 8'h00, 8'h93, 8'h41, 8'h5A, 8'hC3, 8'h12, 8'h34,
                 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h0F, 8'hA5};
        //          sel  cmd    len  rise drop rest  rd val done ab  wr
        vecs[0] = '{1'b0, 8'h04, 4'd3,  0, -1, -1,  4,  3, 25, 1'b0, 2};
        vecs[1] = '{1'b1, 8'h29, 4'd0,  0, -1, -1,  0,  0,  4, 1'b0, 2};
        vecs[2] = '{1'b0, 8'h09, 4'd1, 10, -1, -1,  2,  1, 24, 1'b0, 11};
        vecs[3] = '{1'b0, 8'h04, 4'd3,  0, 10, -1,  2,  0, 15, 1'b1, 2};
        vecs[4] = '{1'b1, 8'h04, 4'd3,  0, 10, -1,  2,  1, 15, 1'b1, 2};
        vecs[5] = '{1'b1, 8'h09, 4'd2,  0, -1, -1,  2,  2, 15, 1'b0, 2};
        vecs[6] = '{1'b0, 8'h04, 4'd0,  0, -1, -1,  1,  0, 10, 1'b0, 2};
        vecs[7] = '{1'b0, 8'h04, 4'd15, 0, -1, -1, 16, 15, 85, 1'b0, 2};
        vecs[8] = '{1'b0, 8'h04, 4'd2,  0, -1,  8,  3,  2, 20, 1'b0, 2};
        vecs[9] = '{1'b0, 8'h09, 4'd2,  0,  3, -1,  0,  0,  4, 1'b1, 2};

        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check($sformatf("reset_state%0d", s),
                  {wr_m, rd_m, dc_m, oe_m, db_m, req_m, busy_m, data_m, valid_m, done_m, abort_m},
                  {1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        end
        sel = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Reset lands while the first read strobe is low.
        @(negedge clk);
        sel = 1'b0; cmd = 8'h04; rd_len = 4'd3; bus_gnt = 1'b1; start = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_reset_rd_low", rd_m, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("mid_reset_pins", {rd_m, wr_m, dc_m, oe_m, req_m, busy_m}, 6'b111000);
        @(negedge clk);
        reset = 1'b0;
        run_vec(vecs[0], 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
